// File: rtl/mesh_result_unloader.sv
// mesh_result_unloader: snapshots the flat mesh result bus on request and
// streams it out MSB-first as DW-bit words over a valid/ready interface.
// A capture request on the final-transfer edge starts the next frame with no
// idle bubble. Requests that arrive mid-frame are dropped and counted.
module mesh_result_unloader #(
    parameter int unsigned NODES = 468,
    parameter int unsigned NBITS = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NODES*NBITS-1:0]                  mesh_out,
    input  logic                                    cap_req,
    output logic                                    cap_busy,
    output logic [DW-1:0]                           m_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_last,
    output logic [$clog2((NODES*NBITS)/DW)-1:0]     m_word_idx,
    output logic [CW-1:0]                           ovf_cnt
);

    localparam int unsigned W      = NODES * NBITS;
    localparam int unsigned NWORDS = W / DW;
    localparam int unsigned IW     = $clog2(NWORDS);
    // Index one before the final word: reaching it arms m_last for the next word.
    localparam logic [IW-1:0] PEN_IDX = IW'(NWORDS - 2);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    logic [W-1:0]    snap;
    logic [IW-1:0]   idx;
    logic            last_q;
    logic [CW-1:0]   ovf_q;

    logic            xfer;
    logic            final_xfer;

    assign xfer       = (state == STREAM) && m_ready;
    assign final_xfer = xfer && last_q;

    // Frame FSM: capture into the snapshot, then shift one word out per transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            snap   <= '0;
            idx    <= '0;
            last_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cap_req) begin
                        snap   <= mesh_out;
                        idx    <= '0;
                        last_q <= (NWORDS == 1);
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last_q) begin
                            if (cap_req) begin
                                // Back-to-back frame: reload in place, stay streaming.
                                snap   <= mesh_out;
                                idx    <= '0;
                                last_q <= (NWORDS == 1);
                            end else begin
                                last_q <= 1'b0;
                                idx    <= '0;
                                state  <= IDLE;
                            end
                        end else begin
                            snap   <= snap << DW;
                            idx    <= idx + 1'b1;
                            last_q <= (idx == PEN_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of capture requests dropped while a frame is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else if ((state == STREAM) && cap_req && !final_xfer && (ovf_q != '1)) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign m_valid    = (state == STREAM);
    assign cap_busy   = (state == STREAM);
    assign m_last     = last_q;
    assign m_word_idx = idx;
    assign m_data     = snap[W-1 -: DW];
    assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_mesh_result_unloader.sv
// Bench for mesh_result_unloader: node-level reference model plus directed
// scenarios for capture, stalls, back-to-back frames, drops and async reset.
module tb_mesh_result_unloader;

    localparam int W  = 1872;
    localparam int NW = 117;
    localparam int NN = 468;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  mesh_out = '0;
    logic          cap_req = 1'b0;
    logic          m_ready = 1'b0;
    logic          cap_busy;
    logic [15:0]   m_data;
    logic          m_valid;
    logic          m_last;
    logic [6:0]    m_word_idx;
    logic [7:0]    ovf_cnt;

    mesh_result_unloader dut (
        .clk        (clk),
        .rst        (rst),
        .mesh_out   (mesh_out),
        .cap_req    (cap_req),
        .cap_busy   (cap_busy),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .m_word_idx (m_word_idx),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame held as a node array, words built from nodes.
    logic [3:0]   m_nodes [NN];
    logic [W-1:0] m_cap;
    bit           m_busy = 0;
    int           m_k = 0;
    int           m_ovf = 0;
    bit           mdl_was_busy;
    bit           mdl_fin;

    function automatic logic [15:0] exp_word(input int k);
        return {m_nodes[4*k], m_nodes[4*k+1], m_nodes[4*k+2], m_nodes[4*k+3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0;
            m_k    = 0;
            m_ovf  = 0;
        end else begin
            mdl_was_busy = m_busy;
            mdl_fin      = m_busy && m_ready && (m_k == NW - 1);
            if (m_busy && m_ready) begin
                if (m_k == NW - 1) m_busy = 0;
                else m_k++;
            end
            if (cap_req) begin
                if (!mdl_was_busy || mdl_fin) begin
                    for (int j = 0; j < NN; j++) m_nodes[j] = mesh_out[4*(NN-1-j) +: 4];
                    m_cap  = mesh_out;
                    m_busy = 1;
                    m_k    = 0;
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
            end
        end
    end

    // Compare process plus receive-side frame reassembly.
    logic [15:0]  rx [NW];
    int           rx_n = 0;
    int           total_xfers = 0;
    bit           prev_stall = 0;
    logic [15:0]  prev_data;
    logic [6:0]   prev_idx;
    logic [W-1:0] rx_vec;

    always @(negedge clk) begin
        if (rst) begin
            rx_n       = 0;
            prev_stall = 0;
        end else begin
            chk("m_valid", m_valid, m_busy);
            chk("cap_busy", cap_busy, m_busy);
            chk("ovf_cnt", ovf_cnt, m_ovf);
            if (m_busy) begin
                chk("m_word_idx", m_word_idx, m_k);
                chk("m_last", m_last, m_k == NW - 1);
                chk("m_data", m_data, exp_word(m_k));
            end
            if (prev_stall) begin
                chk("stall_data", m_data, prev_data);
                chk("stall_idx", m_word_idx, prev_idx);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_word_idx;
            if (m_valid && m_ready) begin
                if (rx_n < NW) rx[rx_n] = m_data;
                rx_n++;
                total_xfers++;
                if (m_last) begin
                    rx_vec = '0;
                    for (int i = 0; i < NW; i++) rx_vec[W-1-16*i -: 16] = rx[i];
                    chk("frame_len", rx_n, NW);
                    chk("frame_concat", rx_vec == m_cap, 1);
                    rx_n = 0;
                end
            end
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_last(input string name);
        int n;
        n = 0;
        while (!m_last && n < 400) begin
            step();
            n++;
        end
        if (!m_last) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic randomize_mesh();
        for (int w = 0; w < NW; w++) mesh_out[16*w +: 16] = 16'($urandom);
    endtask

    logic [W-1:0] p1;
    logic [W-1:0] p2;
    int           n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        p1 = '0;
        p1[W-1 -: 4] = 4'hA;
        p1[3:0]      = 4'h5;
        p2 = '0;
        p2[W-1 -: 16] = 16'h1234;
        p2[15:0]      = 16'hBEEF;

        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", cap_busy, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_idx", m_word_idx, 0);
        chk("rst_ovf", ovf_cnt, 0);

        // Single frame, consumer always ready.
        mesh_out = p1;
        cap_req  = 1'b1;
        m_ready  = 1'b1;
        step();
        cap_req = 1'b0;
        chk("t1_word0", m_data, 16'hA000);
        chk("t1_idx0", m_word_idx, 0);
        chk("t1_valid", m_valid, 1);
        wait_last("t1");
        chk("t1_last_word", m_data, 16'h0005);
        chk("t1_last_idx", m_word_idx, 116);
        step();
        chk("t1_valid_fall", m_valid, 0);
        chk("t1_last_fall", m_last, 0);
        chk("t1_xfers", total_xfers, 117);

        // Stalling consumer with the bus churning after capture.
        mesh_out = p1;
        cap_req  = 1'b1;
        m_ready  = 1'b1;
        step();
        cap_req = 1'b0;
        n = 0;
        while (m_valid && n < 700) begin
            randomize_mesh();
            m_ready = (n % 4 == 0) || (n % 4 == 3);
            step();
            n++;
        end
        chk("t2_done", m_valid, 0);

        // Back-to-back capture on the final-transfer edge.
        m_ready  = 1'b1;
        mesh_out = p1;
        cap_req  = 1'b1;
        step();
        cap_req = 1'b0;
        wait_last("t3");
        mesh_out = p2;
        cap_req  = 1'b1;
        step();
        cap_req = 1'b0;
        chk("t3_valid", m_valid, 1);
        chk("t3_idx", m_word_idx, 0);
        chk("t3_word0", m_data, 16'h1234);
        chk("t3_ovf", ovf_cnt, 0);
        wait_last("t3b");
        chk("t3_last_word", m_data, 16'hBEEF);
        step();
        chk("t3_idle", m_valid, 0);

        // Dropped requests: three while stalled, then many more across frames.
        randomize_mesh();
        cap_req = 1'b1;
        m_ready = 1'b0;
        step();
        cap_req = 1'b0;
        randomize_mesh();
        for (int i = 0; i < 3; i++) begin
            cap_req = 1'b1;
            step();
            cap_req = 1'b0;
            step();
        end
        chk("t4_ovf3", ovf_cnt, 3);
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            randomize_mesh();
            cap_req = 1'b1;
            step();
            cap_req = 1'b0;
            step();
        end
        chk("t4_ovf_sat", ovf_cnt, 8'hFF);
        n = 0;
        while (m_valid && n < 200) begin
            step();
            n++;
        end
        chk("t4_drain", m_valid, 0);

        // Asynchronous reset mid-frame.
        randomize_mesh();
        cap_req = 1'b1;
        step();
        cap_req = 1'b0;
        n = 0;
        while (m_word_idx != 7'd50 && n < 200) begin
            step();
            n++;
        end
        chk("t5_reach_idx50", m_word_idx, 50);
        #1 rst = 1'b1;
        #1;
        chk("t5_valid", m_valid, 0);
        chk("t5_busy", cap_busy, 0);
        chk("t5_last", m_last, 0);
        chk("t5_idx", m_word_idx, 0);
        chk("t5_ovf", ovf_cnt, 0);
        step();
        step();
        rst = 1'b0;

        // Ready in idle with no request: nothing happens.
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t6_idle_valid", m_valid, 0);
        end
        chk("t6_idle_idx", m_word_idx, 0);
        chk("t6_idle_data", m_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mesh_result_unloader.md
Name: mesh_result_unloader

Overview:
- Downstream stage of the 26x18 two-bit torus mesh (468 nodes, 4 result bits per node, 1872-bit flat result bus).
- On a capture request, snapshots the full mesh result bus in one cycle, then streams it out as 16-bit words over a valid/ready interface for a host/FIFO/UART bridge.
- Decouples the free-running mesh from a narrow, back-pressured consumer.

Parameters:
- NODES, 468, number of mesh nodes (26 x 18).
- NBITS, 4, result bits per node.
- DW, 16, output word width; NODES*NBITS must be an exact multiple of DW (1872/16 = 117 words).
- CW, 8, width of the overflow counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- mesh_out  input  1872  mesh result bus; node j occupies bits [4*(467-j)+3 : 4*(467-j)], so node 0 is at the MSBs.
- cap_req  input  1  single-cycle request to snapshot mesh_out and start a frame.
- cap_busy  output  1  high while a frame is being streamed.
- m_data  output  16  current output word.
- m_valid  output  1  m_data is valid.
- m_ready  input  1  consumer accepts m_data this cycle.
- m_last  output  1  high with the final word of the frame.
- m_word_idx  output  7  index (0..116) of the word on m_data.
- ovf_cnt  output  8  saturating count of cap_req pulses dropped while busy.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, snapshot register=0, word index=0; m_valid=0, m_last=0, m_data=0, m_word_idx=0, cap_busy=0, ovf_cnt=0. Reset asserted mid-frame aborts the frame immediately with no further words.
- States: IDLE, STREAM.
- IDLE:
  - cap_req=1 at a rising edge: mesh_out is latched into the 1872-bit snapshot register at that edge. Next state is STREAM with index 0.
  - The first word is presented the cycle after the edge: 1-cycle capture latency.
- STREAM:
  - m_valid=1 and cap_busy=1.
  - m_data = snapshot[1871-16*k -: 16] for index k, so word 0 = nodes 0..3 and node 0 is in m_data[15:12].
  - m_word_idx = k.
  - m_last = 1 exactly when k = 116.
- Handshake:
  - A transfer occurs on any edge where m_valid & m_ready.
  - On transfer with k<116, k increments.
  - On transfer with k=116, the frame ends.
  - While m_valid=1 and m_ready=0, m_data, m_word_idx and m_last hold stable.
  - m_valid never drops before the last transfer.
- Frame end:
  - If cap_req=0 on the final-transfer edge: return to IDLE, with m_valid=0 and m_last=0 the next cycle.
  - If cap_req=1 on the same edge: this is a back-to-back capture. mesh_out is snapshotted at that edge, the block stays in STREAM with k=0, and there is no idle bubble.
- Drops:
  - cap_req=1 in STREAM on any edge other than the final-transfer edge is ignored; the snapshot is unchanged.
  - Each such pulse increments ovf_cnt, saturating at 255.
  - ovf_cnt is cleared only by rst.
- Snapshot isolation: changes on mesh_out after the capture edge never affect the frame being streamed.
- m_ready while in IDLE is ignored.
- Implementation: the snapshot may be realised as a shift register (shift left by DW per transfer) or as an indexed mux. Observable behaviour must match the above.
- Throughput: with m_ready held high, one frame takes 117 cycles after capture, and continuous capture yields 117 words per 117 cycles.

Test Plan:
- Reset, then cap_req with mesh_out = 1872'h0 except node 0 = 4'hA and node 467 = 4'h5, m_ready=1 -> word 0 = 16'hA000 at idx 0; words 1..115 = 0; word 116 = 16'h0005 with m_last=1; m_valid falls the next cycle; 117 transfers total.
- Same frame with m_ready toggling 1,0,0,1 repeatedly and mesh_out randomised after capture -> m_data/idx stable during stalls; the received 117 words concatenate exactly to the captured value.
- cap_req asserted on the final-transfer edge with a new mesh_out pattern -> next cycle shows idx 0 of the new frame, m_valid stays 1, ovf_cnt unchanged.
- Three cap_req pulses mid-frame, then 300 more mid-frame pulses across later frames -> ovf_cnt reads 3, then saturates at 8'hFF; the current frame's data is unaltered.
- rst asserted asynchronously (between edges) at idx 50 -> m_valid, cap_busy, m_last, m_word_idx and ovf_cnt go to 0 immediately; no words are emitted until a new cap_req.
- m_ready=1 in IDLE with no cap_req for 20 cycles -> m_valid stays 0 and no state change.
